// File: rtl/uart_link_pkg.sv
// Shared encodings and defaults for the UART work link: FSM states,
// default parameter values and status bit positions.
package uart_link_pkg;

   localparam int HDR_BYTES_DEF   = 80;
   localparam int RES_BYTES_DEF   = 4;
   localparam int TIMEOUT_CYC_DEF = 5000000;

   localparam int ST_TX_ACTIVE    = 0;
   localparam int ST_RX_TIMEOUT   = 1;
   localparam int ST_RES_OVERFLOW = 2;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RECV = 1'b1
   } rx_state_e;

   typedef enum logic [1:0] {
      T_IDLE   = 2'd0,
      T_SEND   = 2'd1,
      T_WAITHI = 2'd2,
      T_WAITLO = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uwl_result_tx.sv
// Result path: registered push-edge detect, 2-entry result FIFO and a
// byte serializer that hands bytes MSB-first to the UART transmitter.
module uwl_result_tx
   import uart_link_pkg::*;
#(
   parameter int RES_BYTES = RES_BYTES_DEF
) (
   input  logic                   clock,
   input  logic                   rst_n,
   input  logic [8*RES_BYTES-1:0] i_res_data,
   input  logic                   i_res_push,
   input  logic                   i_tx_busy,
   output logic [7:0]             o_tx_data,
   output logic                   o_tx_wr,
   output logic                   o_active,
   output logic                   o_overflow
);

   localparam int RW   = 8 * RES_BYTES;
   localparam int BI_W = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;

   logic              r_push_d;
   logic [RW-1:0]     r_mem [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_cnt;
   logic              r_overflow;
   tx_state_e         r_state;
   tx_state_e         w_state_nx;
   logic [BI_W-1:0]   r_bidx;
   logic              r_hi_cnt;
   logic [RW-1:0]     r_shift;

   logic w_push;
   logic w_full;
   logic w_empty;
   logic w_wr_en;
   logic w_load;
   logic w_next;
   logic w_pop;
   logic w_wr;

   assign w_push  = i_res_push & ~r_push_d;
   assign w_full  = (r_cnt == 2'd2);
   assign w_empty = (r_cnt == 2'd0);
   // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
   assign w_wr_en = w_push & (~w_full | w_pop);

   always_ff @(posedge clock) begin
      if (w_wr_en) r_mem[r_wptr] <= i_res_data;
   end

   always_comb begin
      w_state_nx = r_state;
      w_load     = 1'b0;
      w_next     = 1'b0;
      w_pop      = 1'b0;
      w_wr       = 1'b0;
      case (r_state)
         T_IDLE: begin
            if (!w_empty) begin
               w_load     = 1'b1;
               w_state_nx = T_SEND;
            end
         end
         T_SEND: begin
            if (!i_tx_busy) begin
               w_wr       = 1'b1;
               w_state_nx = T_WAITHI;
            end
         end
         T_WAITHI: begin
            if (i_tx_busy || r_hi_cnt) w_state_nx = T_WAITLO;
         end
         T_WAITLO: begin
            if (!i_tx_busy) begin
               w_next = 1'b1;
               if (r_bidx == BI_W'(RES_BYTES - 1)) begin
                  w_pop      = 1'b1;
                  w_state_nx = T_IDLE;
               end else begin
                  w_state_nx = T_SEND;
               end
            end
         end
         default: w_state_nx = T_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_push_d   <= 1'b0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_cnt      <= 2'd0;
         r_overflow <= 1'b0;
         r_state    <= T_IDLE;
         r_bidx     <= '0;
         r_hi_cnt   <= 1'b0;
         r_shift    <= '0;
      end else begin
         r_push_d <= i_res_push;
         r_wptr   <= r_wptr ^ w_wr_en;
         r_rptr   <= r_rptr ^ w_pop;
         case ({w_wr_en, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
         r_state  <= w_state_nx;
         // Second consecutive WAITHI clock ends the wait even without busy.
         r_hi_cnt <= (r_state == T_WAITHI) && (w_state_nx == T_WAITHI);
         if (w_load) r_bidx <= '0;
         else if (w_next && !w_pop) r_bidx <= r_bidx + 1'b1;
         if (w_load) r_shift <= r_mem[r_rptr];
         else if (w_next) r_shift <= r_shift << 8;
      end
   end

   assign o_tx_data  = r_shift[RW-1 -: 8];
   assign o_tx_wr    = w_wr;
   assign o_active   = (r_state != T_IDLE);
   assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_work_link.sv
// UART work link: assembles fixed-length headers from received bytes and
// returns result words over the UART transmitter, both paths concurrent.
module uart_work_link
   import uart_link_pkg::*;
#(
   parameter int HDR_BYTES   = HDR_BYTES_DEF,
   parameter int RES_BYTES   = RES_BYTES_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [7:0]             rx_data,
   input  logic                   rx_rdy,
   output logic                   rx_clr,
   output logic [8*HDR_BYTES-1:0] header_data,
   output logic                   header_valid,
   input  logic [8*RES_BYTES-1:0] res_data,
   input  logic                   res_push,
   output logic [7:0]             tx_data,
   output logic                   tx_wr,
   input  logic                   tx_busy,
   output logic [31:0]            byte_count,
   output logic [2:0]             status
);

   localparam int HW    = 8 * HDR_BYTES;
   localparam int IDX_W = $clog2(HDR_BYTES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC);

   logic r_rst_meta;
   logic r_rst_sync;
   logic w_rst_n;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   assign w_rst_n = r_rst_sync;

   rx_state_e        r_rx_state;
   rx_state_e        w_rx_state_nx;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nx;
   logic [TO_W-1:0]  r_to_cnt;
   logic [TO_W-1:0]  w_to_cnt_nx;
   logic             r_rx_clr;
   logic             r_hdr_valid;
   logic             r_rx_timeout;
   logic [HW-1:0]    r_hdr;
   logic [31:0]      r_byte_cnt;
   logic [HW-1:0]    w_rx_ext;
   logic             w_accept;
   logic             w_last;
   logic             w_timeout;
   logic             w_tx_active;
   logic             w_overflow;

   // rx_rdy is still high in the cycle rx_clr is out, so that cycle is ignored.
   assign w_accept = rx_rdy & ~r_rx_clr;
   assign w_rx_ext = HW'(rx_data);

   always_comb begin
      w_rx_state_nx = r_rx_state;
      w_idx_nx      = r_idx;
      w_to_cnt_nx   = '0;
      w_last        = 1'b0;
      w_timeout     = 1'b0;
      case (r_rx_state)
         R_IDLE: begin
            if (w_accept) begin
               if (HDR_BYTES == 1) begin
                  w_last = 1'b1;
               end else begin
                  w_idx_nx      = IDX_W'(1);
                  w_rx_state_nx = R_RECV;
               end
            end
         end
         R_RECV: begin
            if (w_accept) begin
               if (r_idx == IDX_W'(HDR_BYTES - 1)) begin
                  w_last        = 1'b1;
                  w_idx_nx      = '0;
                  w_rx_state_nx = R_IDLE;
               end else begin
                  w_idx_nx = r_idx + 1'b1;
               end
            end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
               w_timeout     = 1'b1;
               w_idx_nx      = '0;
               w_rx_state_nx = R_IDLE;
            end else begin
               w_to_cnt_nx = r_to_cnt + 1'b1;
            end
         end
         default: w_rx_state_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_rx_state   <= R_IDLE;
         r_idx        <= '0;
         r_to_cnt     <= '0;
         r_rx_clr     <= 1'b0;
         r_hdr_valid  <= 1'b0;
         r_rx_timeout <= 1'b0;
         r_hdr        <= '0;
         r_byte_cnt   <= '0;
      end else begin
         r_rx_state  <= w_rx_state_nx;
         r_idx       <= w_idx_nx;
         r_to_cnt    <= w_to_cnt_nx;
         r_rx_clr    <= w_accept;
         r_hdr_valid <= w_last;
         if (w_accept) begin
            r_hdr      <= (r_hdr << 8) | w_rx_ext;
            r_byte_cnt <= r_byte_cnt + 32'd1;
         end
         if (w_timeout) r_rx_timeout <= 1'b1;
         else if (w_last) r_rx_timeout <= 1'b0;
      end
   end

   uwl_result_tx #(
      .RES_BYTES (RES_BYTES)
   ) u_result_tx (
      .clock      (clock),
      .rst_n      (w_rst_n),
      .i_res_data (res_data),
      .i_res_push (res_push),
      .i_tx_busy  (tx_busy),
      .o_tx_data  (tx_data),
      .o_tx_wr    (tx_wr),
      .o_active   (w_tx_active),
      .o_overflow (w_overflow)
   );

   assign rx_clr       = r_rx_clr;
   assign header_data  = r_hdr;
   assign header_valid = r_hdr_valid;
   assign byte_count   = r_byte_cnt;

   always_comb begin
      status                  = '0;
      status[ST_TX_ACTIVE]    = w_tx_active;
      status[ST_RX_TIMEOUT]   = r_rx_timeout;
      status[ST_RES_OVERFLOW] = w_overflow;
   end

endmodule

// File: tb/tb_uart_work_link.sv
// Directed-sequence bench for uart_work_link with random payloads checked
// against a byte-queue model of the header stream and result words.
module tb_uart_work_link;

   localparam int HB = 80;
   localparam int RB = 4;
   localparam int TO = 64;
   localparam int HW = 8 * HB;
   typedef logic [HW-1:0] wide_t;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [7:0]      rx_data = '0;
   logic            rx_rdy = 1'b0;
   logic            rx_clr;
   logic [HW-1:0]   header_data;
   logic            header_valid;
   logic [8*RB-1:0] res_data = '0;
   logic            res_push = 1'b0;
   logic [7:0]      tx_data;
   logic            tx_wr;
   logic            tx_busy = 1'b0;
   logic [31:0]     byte_count;
   logic [2:0]      status;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_wr  = 0;
   int          n_hv  = 0;
   wide_t       cap_hdr = '0;
   logic [7:0]  q_tx[$];
   logic [7:0]  q_rx[$];
   int unsigned m_cnt = 0;

   uart_work_link #(
      .HDR_BYTES   (HB),
      .RES_BYTES   (RB),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_rdy       (rx_rdy),
      .rx_clr       (rx_clr),
      .header_data  (header_data),
      .header_valid (header_valid),
      .res_data     (res_data),
      .res_push     (res_push),
      .tx_data      (tx_data),
      .tx_wr        (tx_wr),
      .tx_busy      (tx_busy),
      .byte_count   (byte_count),
      .status       (status)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input wide_t obs, input wide_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected header: the most recent HB bytes received, oldest in the MSBs.
   function automatic wide_t exp_hdr();
      wide_t r;
      int k;
      r = '0;
      for (int i = 0; i < HB; i++) begin
         k = q_rx.size() - HB + i;
         if (k >= 0) r[8*(HB-1-i) +: 8] = q_rx[k];
      end
      return r;
   endfunction

   function automatic logic [7:0] word_byte(input logic [8*RB-1:0] w, input int i);
      return w[8*(RB-1-i) +: 8];
   endfunction

   // Output monitor: captures transmitted bytes and header pulses.
   initial begin
      forever begin
         @(negedge clock);
         if (tx_wr === 1'b1) begin
            n_wr++;
            q_tx.push_back(tx_data);
            check("tx_wr_while_busy", wide_t'(tx_busy), wide_t'(0));
         end
         if (header_valid === 1'b1) begin
            n_hv++;
            cap_hdr = header_data;
         end
      end
   end

   // Transmitter model: goes busy one clock after each write for a random time.
   initial begin
      forever begin
         @(negedge clock);
         if (tx_wr === 1'b1) begin
            @(posedge clock);
            #1 tx_busy = 1'b1;
            repeat ($urandom_range(3, 8)) @(posedge clock);
            #1 tx_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      int t;
      @(posedge clock);
      #1 rx_data = b;
      rx_rdy = 1'b1;
      t = 0;
      do begin
         @(negedge clock);
         t++;
      end while (rx_clr !== 1'b1 && t < 20);
      check("rx_clr_latency", wide_t'(t), wide_t'(2));
      @(posedge clock);
      #1 rx_rdy = 1'b0;
      q_rx.push_back(b);
      m_cnt++;
      repeat ($urandom_range(0, 3)) @(posedge clock);
   endtask

   task automatic push_word(input logic [8*RB-1:0] w);
      @(posedge clock);
      #1 res_data = w;
      res_push = 1'b1;
      repeat (2) @(posedge clock);
      #1 res_push = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic wait_tx(input int n);
      int t;
      t = 0;
      while (q_tx.size() < n && t < 3000) begin
         @(negedge clock);
         t++;
      end
      check("tx_byte_total", wide_t'(q_tx.size()), wide_t'(n));
   endtask

   task automatic check_word(input string tag, input logic [8*RB-1:0] w, input int base);
      for (int i = 0; i < RB; i++) begin
         if (q_tx.size() > base + i) check(tag, wide_t'(q_tx[base+i]), wide_t'(word_byte(w, i)));
         else check(tag, wide_t'(0), wide_t'(1));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_header_data"},  header_data,               wide_t'(0));
      check({tag, "_header_valid"}, wide_t'(header_valid),     wide_t'(0));
      check({tag, "_rx_clr"},       wide_t'(rx_clr),           wide_t'(0));
      check({tag, "_tx_data"},      wide_t'(tx_data),          wide_t'(0));
      check({tag, "_tx_wr"},        wide_t'(tx_wr),            wide_t'(0));
      check({tag, "_byte_count"},   wide_t'(byte_count),       wide_t'(0));
      check({tag, "_status"},       wide_t'(status),           wide_t'(0));
   endtask

   initial begin
      logic [8*RB-1:0] w1, w2, w3;
      int hv0, wr0, t;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check_idle_outputs("reset");
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (4) @(posedge clock);

      // Header of 0x01..0x50.
      hv0 = n_hv;
      for (int i = 1; i <= HB; i++) send_byte(8'(i));
      repeat (3) @(negedge clock);
      check("hdr1_pulses",   wide_t'(n_hv - hv0),      wide_t'(1));
      check("hdr1_first",    wide_t'(cap_hdr[HW-1 -: 8]), wide_t'(8'h01));
      check("hdr1_last",     wide_t'(cap_hdr[7:0]),    wide_t'(8'h50));
      check("hdr1_full",     cap_hdr,                  exp_hdr());
      check("hdr1_count",    wide_t'(byte_count),      wide_t'(m_cnt));
      check("hdr1_timeout",  wide_t'(status[1]),       wide_t'(0));

      // Fixed result word.
      q_tx.delete();
      push_word(32'hDEADBEEF);
      wait_tx(1);
      check("tx_active_on", wide_t'(status[0]), wide_t'(1));
      wait_tx(4);
      check_word("deadbeef_byte", 32'hDEADBEEF, 0);
      repeat (30) @(negedge clock);
      check("deadbeef_extra", wide_t'(q_tx.size()), wide_t'(4));
      check("tx_active_off",  wide_t'(status[0]),   wide_t'(0));
      check("no_overflow",    wide_t'(status[2]),   wide_t'(0));

      // Result transmission overlapping a full header reception.
      q_tx.delete();
      hv0 = n_hv;
      w1 = $urandom;
      push_word(w1);
      for (int i = 0; i < HB; i++) send_byte(8'($urandom));
      wait_tx(4);
      check_word("conc_tx_byte", w1, 0);
      repeat (3) @(negedge clock);
      check("conc_pulses", wide_t'(n_hv - hv0),  wide_t'(1));
      check("conc_hdr",    cap_hdr,              exp_hdr());
      check("conc_count",  wide_t'(byte_count),  wide_t'(m_cnt));

      // Partial header abandoned by the inter-byte timeout.
      hv0 = n_hv;
      for (int i = 0; i < 10; i++) send_byte(8'($urandom));
      check("part_no_timeout", wide_t'(status[1]), wide_t'(0));
      repeat (TO + 1) @(posedge clock);
      @(negedge clock);
      check("timeout_set",     wide_t'(status[1]),  wide_t'(1));
      check("timeout_hdr",     header_data,         exp_hdr());
      check("timeout_pulses",  wide_t'(n_hv - hv0), wide_t'(0));
      for (int i = 0; i < HB; i++) send_byte(8'($urandom));
      repeat (3) @(negedge clock);
      check("after_to_pulses", wide_t'(n_hv - hv0),  wide_t'(1));
      check("after_to_hdr",    cap_hdr,              exp_hdr());
      check("timeout_clear",   wide_t'(status[1]),   wide_t'(0));
      check("after_to_count",  wide_t'(byte_count),  wide_t'(m_cnt));

      // Three pushes during one transmission: the third is dropped.
      q_tx.delete();
      w1 = $urandom;
      w2 = $urandom;
      w3 = $urandom;
      push_word(w1);
      wait_tx(1);
      push_word(w2);
      push_word(w3);
      wait_tx(2 * RB);
      repeat (150) @(negedge clock);
      check("ovf_total", wide_t'(q_tx.size()), wide_t'(2 * RB));
      check_word("ovf_word1", w1, 0);
      check_word("ovf_word2", w2, RB);
      check("ovf_flag",  wide_t'(status[2]),   wide_t'(1));

      // Reset in the middle of a result.
      q_tx.delete();
      wr0 = n_wr;
      push_word($urandom);
      t = 0;
      while (n_wr < wr0 + 2 && t < 3000) begin
         @(negedge clock);
         t++;
      end
      check("rst_pre_bytes", wide_t'(n_wr - wr0), wide_t'(2));
      #2 reset = 1'b0;
      q_rx.delete();
      m_cnt = 0;
      repeat (4) @(negedge clock);
      check_idle_outputs("in_reset");
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (200) @(posedge clock);
      @(negedge clock);
      check("rst_no_more_wr", wide_t'(n_wr - wr0), wide_t'(2));
      check_idle_outputs("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
